// File: rtl/encoder_pkg.sv
// Shared types and constants for the priority encoder
// and its single-wire frame serializer.
package encoder_pkg;

   localparam int FRAME_BITS = 4;
   localparam int IDX_W      = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      BIT1,
      BIT0,
      PAR,
      GAP
   } enc_state_t;

endpackage

// File: rtl/encoder_serializer.sv
// Frame FSM: sends start, code bits, parity, then an idle gap,
// only when the code differs from the last one transmitted.
module encoder_serializer
   import encoder_pkg::*;
#(
   parameter int MIN_GAP = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] code,
   input  logic             valid,
   output logic             out
);

   localparam int CNT_W = 4;

   enc_state_t       state;
   logic [IDX_W-1:0] sent;
   logic             sent_ok;
   logic [CNT_W-1:0] gap_cnt;
   logic             launch;

   // New frame wanted when code is valid and not yet sent
   always_comb begin
      launch = valid && (!sent_ok || (code != sent));
   end

   // Frame sequencer with registered serial output
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         out     <= 1'b0;
         sent    <= '0;
         sent_ok <= 1'b0;
         gap_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (launch) begin
                  state   <= START;
                  out     <= 1'b1;
                  sent    <= code;
                  sent_ok <= 1'b1;
               end else begin
                  out <= 1'b0;
               end
            end
            START: begin
               state <= BIT1;
               out   <= sent[1];
            end
            BIT1: begin
               state <= BIT0;
               out   <= sent[0];
            end
            BIT0: begin
               state <= PAR;
               out   <= ^sent;
            end
            PAR: begin
               state   <= GAP;
               out     <= 1'b0;
               gap_cnt <= CNT_W'(MIN_GAP - 1);
            end
            GAP: begin
               if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - 1'b1;
                  out     <= 1'b0;
               end else if (launch) begin
                  state   <= START;
                  out     <= 1'b1;
                  sent    <= code;
                  sent_ok <= 1'b1;
               end else begin
                  state <= IDLE;
                  out   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               out   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/encoder.sv
// Four-line priority encoder (d > c > b > a) with registered
// index/valid/err and a serial frame output per code change.
module encoder
   import encoder_pkg::*;
#(
   parameter int MIN_GAP = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   output logic             out,
   output logic [IDX_W-1:0] code,
   output logic             valid,
   output logic             err
);

   logic [3:0]       req;
   logic [IDX_W-1:0] idx;
   logic             any;
   logic             multi;

   // Resolve highest-priority request and flag multi-hot
   always_comb begin
      req   = {d, c, b, a};
      any   = |req;
      multi = $countones(req) > 1;
      idx   = '0;
      priority case (1'b1)
         d:       idx = 2'd3;
         c:       idx = 2'd2;
         b:       idx = 2'd1;
         default: idx = 2'd0;
      endcase
   end

   // Parallel outputs; code holds when no line is high
   always_ff @(posedge clk) begin
      if (rst) begin
         code  <= '0;
         valid <= 1'b0;
         err   <= 1'b0;
      end else begin
         valid <= any;
         err   <= multi;
         if (any) begin
            code <= idx;
         end
      end
   end

   encoder_serializer #(
      .MIN_GAP(MIN_GAP)
   ) u_ser (
      .clk  (clk),
      .rst  (rst),
      .code (code),
      .valid(valid),
      .out  (out)
   );

endmodule

// File: tb/tb_encoder.sv
// Randomized and directed checks of encoder against a
// queue-based frame model.
module tb_encoder;

   localparam int GAP = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       a, b, c, d;
   logic       out;
   logic [1:0] code;
   logic       valid;
   logic       err;

   int total = 0;
   int bad   = 0;

   bit         q[$];
   logic       m_out;
   logic [1:0] m_code;
   logic       m_valid;
   logic       m_err;
   logic [1:0] m_last;
   bit         m_have;

   encoder #(.MIN_GAP(GAP)) dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .c    (c),
      .d    (d),
      .out  (out),
      .code (code),
      .valid(valid),
      .err  (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   // One clock of the reference: inputs as driven before the edge
   task automatic model(input logic [3:0] req, input logic r);
      if (r) begin
         q.delete();
         m_out   = 1'b0;
         m_code  = 2'd0;
         m_valid = 1'b0;
         m_err   = 1'b0;
         m_have  = 1'b0;
         return;
      end
      if (q.size() > 0) begin
         m_out = q.pop_front();
      end else if (m_valid && (!m_have || m_code != m_last)) begin
         m_out  = 1'b1;
         m_last = m_code;
         m_have = 1'b1;
         q.push_back(m_code[1]);
         q.push_back(m_code[0]);
         q.push_back(m_code[1] ^ m_code[0]);
         for (int i = 0; i < GAP; i++) q.push_back(1'b0);
      end else begin
         m_out = 1'b0;
      end
      if (req != 4'b0) begin
         for (int i = 0; i < 4; i++)
            if (req[i]) m_code = 2'(i);
         m_valid = 1'b1;
         m_err   = $countones(req) > 1;
      end else begin
         m_valid = 1'b0;
         m_err   = 1'b0;
      end
   endtask

   task automatic cyc(input logic [3:0] req, input logic r, input int n);
      for (int k = 0; k < n; k++) begin
         {d, c, b, a} = req;
         rst = r;
         @(posedge clk);
         model(req, r);
         @(negedge clk);
         chk("out", 8'(out), 8'(m_out));
         chk("code", 8'(code), 8'(m_code));
         chk("valid", 8'(valid), 8'(m_valid));
         chk("err", 8'(err), 8'(m_err));
      end
   endtask

   initial begin
      {d, c, b, a} = 4'b0;
      rst = 1'b1;
      m_last = 2'd0;
      cyc(4'b0000, 1'b1, 3);
      // idle after reset
      cyc(4'b0000, 1'b0, 10);
      // a alone, single frame
      cyc(4'b0001, 1'b0, 10);
      // walk a..d one-hot
      cyc(4'b0010, 1'b0, 8);
      cyc(4'b0100, 1'b0, 8);
      cyc(4'b1000, 1'b0, 8);
      cyc(4'b0001, 1'b0, 8);
      // multi-hot b+d
      cyc(4'b1010, 1'b0, 10);
      cyc(4'b0000, 1'b0, 6);
      // c then a one cycle after START
      cyc(4'b0100, 1'b0, 3);
      cyc(4'b0001, 1'b0, 14);
      // reset during a frame, then same code again
      cyc(4'b0010, 1'b0, 4);
      cyc(4'b0010, 1'b1, 1);
      cyc(4'b0010, 1'b0, 10);
      // random segments with occasional reset
      for (int s = 0; s < 300; s++) begin
         logic [3:0] rq;
         int         len;
         rq  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) rq = 4'b0001 << $urandom_range(0, 3);
         len = $urandom_range(1, 10);
         if ($urandom_range(0, 39) == 0) cyc(rq, 1'b1, 1);
         cyc(rq, 1'b0, len);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
